// File: rtl/activation_skew_feeder.sv
// -----------------------------------------------------------------------------
// activation_skew_feeder
//
// Purpose:
//   Sequencer that sits directly after the activation memory. A pass reads
//   rows 0..SYSTOLIC_SIZE-1 (combinational memory, same-cycle data) and pushes
//   each row into the systolic array with diagonal skew: lane i carries i extra
//   cycles of delay relative to lane 0. Lane slots that carry no element are
//   driven to zero with their valid bit low. Each pass ends with a one-cycle
//   done pulse coinciding with the last valid output.
//
// Ports:
//   clk                in   rising-edge clock
//   rst                in   asynchronous active-high reset
//   start              in   request a pass (only honoured in IDLE, hold low)
//   hold               in   freeze every piece of state (array-side stall)
//   rd_addr            out  activation memory row address
//   activation_inputs  in   row data for rd_addr, lane i at [i*W +: W]
//   act_out            out  skewed lane data, lane i at [i*W +: W]
//   act_valid          out  per-lane valid
//   busy               out  pass in progress
//   done               out  high during the final valid output cycle
// -----------------------------------------------------------------------------
module activation_skew_feeder #(
  parameter int SYSTOLIC_SIZE    = 8,
  parameter int ACTIVATION_WIDTH = 8,
  parameter int ADDR_WIDTH       = $clog2(SYSTOLIC_SIZE)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic                                      hold,
  output logic [ADDR_WIDTH-1:0]                     rd_addr,
  input  logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0] activation_inputs,
  output logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0] act_out,
  output logic [SYSTOLIC_SIZE-1:0]                  act_valid,
  output logic                                      busy,
  output logic                                      done
);

  localparam int S     = SYSTOLIC_SIZE;
  localparam int W     = ACTIVATION_WIDTH;
  localparam int CNT_W = $clog2(2 * SYSTOLIC_SIZE);

  localparam logic [CNT_W-1:0]      LAST_FEED  = CNT_W'(S - 1);
  localparam logic [CNT_W-1:0]      LAST_DRAIN = CNT_W'(2 * S - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW   = ADDR_WIDTH'(S - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             feed_en;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The pass counter runs continuously through FEED and DRAIN (0..2S-1), so
  // the DRAIN exit and the done pulse fall out of a single compare.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!hold) begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (start) state_d = FEED;
        end
        FEED: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_FEED) state_d = DRAIN;
        end
        DRAIN: begin
          if (cnt_q == LAST_DRAIN) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Address is decoded from the frozen state, so hold keeps it stable and it
  // parks on the last row during DRAIN instead of wrapping.
  always_comb begin
    rd_addr = '0;
    if (state_q == FEED)       rd_addr = cnt_q[ADDR_WIDTH-1:0];
    else if (state_q == DRAIN) rd_addr = LAST_ROW;
  end

  assign feed_en = (state_q == FEED);
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DRAIN) && (cnt_q == LAST_DRAIN);

  // Lane i is an (i+1)-deep shift register: stage 0 captures the memory
  // element (or zero outside FEED), stage i drives the output. Zeros keep
  // shifting in while idle so the lines drain themselves.
  for (genvar i = 0; i < S; i++) begin : g_lane
    logic [i:0][W-1:0] data_q, data_d;
    logic [i:0]        valid_q, valid_d;

    always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (!hold) begin
        data_d[0]  = feed_en ? activation_inputs[i*W +: W] : '0;
        valid_d[0] = feed_en;
        for (int k = 1; k <= i; k++) begin
          data_d[k]  = data_q[k-1];
          valid_d[k] = valid_q[k-1];
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q  <= '0;
        valid_q <= '0;
      end else begin
        data_q  <= data_d;
        valid_q <= valid_d;
      end
    end

    assign act_out[i*W +: W] = data_q[i];
    assign act_valid[i]      = valid_q[i];
  end

endmodule
